// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch (IF) and
// load/store (MEM) stages through a variable-latency request/ack handshake.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall_IF,
    output logic                stall_MEM,
    output logic                spurious_ack
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t state;
    logic   last_grant_d;   // 0 = instruction was granted last, 1 = data
    logic   grant_d;
    logic   grant_i;

    // Under contention the side that lost the previous tie wins this one.
    always_comb begin
        grant_d = d_req & (~if_req | ~last_grant_d);
        grant_i = if_req & ~grant_d;
    end

    assign stall_IF  = if_req & ~if_valid;
    assign stall_MEM = d_req & ~d_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            if_valid     <= 1'b0;
            d_valid      <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            spurious_ack <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            // mem_req is the registered handshake level, so any ack outside BUSY lands here
            if (mem_ack && !mem_req)
                spurious_ack <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_wstrb;
                        state     <= BUSY_D;
                        if (if_req)
                            last_grant_d <= 1'b1;
                    end else if (grant_i) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        state     <= BUSY_I;
                        if (d_req)
                            last_grant_d <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_valid <= 1'b1;
                        state    <= RESP_I;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        d_rdata <= mem_rdata;
                        d_valid <= 1'b1;
                        state   <= RESP_D;
                    end
                end
                // Requests are ignored here so a still-held request is not serviced twice.
                RESP_I, RESP_D: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

endmodule
